// File: rtl/mssd_pkg.sv
// Shared types and constants for the MSSD serial frame transmitter.
// Frame: start bit, dest (MSB first), len (MSB first), data[0..N-1], stop bit.
package mssd_pkg;

  localparam int DEST_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 15;
  localparam int SH_W   = DEST_W + LEN_W + DATA_W;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic [3:0] DST_BITS  = 4'd2;
  localparam logic [3:0] LEN_BITS  = 4'd4;
  localparam logic [3:0] GUARD_CYC = 4'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STRT = 3'd1,
    SDST = 3'd2,
    SLEN = 3'd3,
    SDAT = 3'd4,
    STOP = 3'd5,
    GARD = 3'd6
  } state_e;

  // Lays the header fields out so bit 0 is always the next bit on the wire:
  // dest and len are reversed (they go MSB first), data already goes LSB first.
  function automatic logic [SH_W-1:0] frame_bits(input logic [DEST_W-1:0] d,
                                                  input logic [LEN_W-1:0]  l,
                                                  input logic [DATA_W-1:0] x);
    logic [SH_W-1:0] f;
    f = '0;
    f[SH_W-1:DEST_W+LEN_W] = x;
    for (int i = 0; i < DEST_W; i++) f[i] = d[DEST_W-1-i];
    for (int i = 0; i < LEN_W; i++)  f[DEST_W+i] = l[LEN_W-1-i];
    return f;
  endfunction

endpackage

// File: rtl/mssd_bit_cnt.sv
// Per-phase bit counter; endCnt flags the last cycle of a phase of 'limit' cycles.
module mssd_bit_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] limit,
  output logic       endCnt
);

  logic [3:0] count;

  assign endCnt = en && (count == limit - 4'd1);

  // Holds at the terminal value instead of wrapping; the phase change clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 count <= '0;
    else if (clr)             count <= '0;
    else if (en && !endCnt)   count <= count + 4'd1;
  end

endmodule

// File: rtl/mssd_frame_tx.sv
// MSSD frame transmitter: captures dest/len/data on start and shifts a framed word out on serOut.
// Build option MSSD_TX_GUARD_EN adds a 2-cycle guard state between STOP and IDLE.
module mssd_frame_tx
  import mssd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DEST_W-1:0] dest,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              serOut,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  state_e            state, state_nxt;
  logic [SH_W-1:0]   sh;
  logic [LEN_W-1:0]  len_q;
  logic              accept;
  logic              cnt_clr;
  logic              cnt_en;
  logic              end_cnt;
  logic [3:0]        cnt_limit;

  assign ready  = (state == IDLE);
  assign busy   = ~ready;
  assign done   = (state == STOP);
  assign accept = start & ready;

  always_comb begin
    cnt_limit = 4'd1;
    case (state)
      SDST:    cnt_limit = DST_BITS;
      SLEN:    cnt_limit = LEN_BITS;
      SDAT:    cnt_limit = len_q;
      GARD:    cnt_limit = GUARD_CYC;
      default: cnt_limit = 4'd1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)  state_nxt = STRT;
      STRT: if (end_cnt) state_nxt = SDST;
      SDST: if (end_cnt) state_nxt = SLEN;
      SLEN: if (end_cnt) state_nxt = (len_q == '0) ? STOP : SDAT;
      SDAT: if (end_cnt) state_nxt = STOP;
      STOP: if (end_cnt) begin
`ifdef MSSD_TX_GUARD_EN
        state_nxt = GARD;
`else
        state_nxt = IDLE;
`endif
      end
      GARD: if (end_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every phase change restarts the count from zero.
  assign cnt_clr = (state_nxt != state);
  assign cnt_en  = (state != IDLE);

  mssd_bit_cnt u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limit  (cnt_limit),
    .endCnt (end_cnt)
  );

  // serOut is loaded with the bit belonging to the state being entered, so it
  // lines up cycle-for-cycle with state (and hence with done).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sh     <= '0;
      len_q  <= '0;
      serOut <= IDLE_LVL;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sh    <= frame_bits(dest, len, data);
        len_q <= len;
      end else if (state_nxt == SDST || state_nxt == SLEN || state_nxt == SDAT) begin
        sh <= sh >> 1;
      end
      case (state_nxt)
        STRT:             serOut <= START_LVL;
        SDST, SLEN, SDAT: serOut <= sh[0];
        STOP:             serOut <= STOP_LVL;
        default:          serOut <= IDLE_LVL;
      endcase
    end
  end

endmodule

// File: doc/mssd_frame_tx.md
MSSD_FRAME_TX -- requirements
Module: mssd_frame_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-low reset.
REQ-002 The block SHALL provide the following ports, listed after clk and rst:
- start  input  1  frame request; sampled only when ready=1.
- dest  input  2  destination channel, 0..3.
- len  input  4  data-bit count N, 0..15.
- data  input  15  payload; data[0] is sent first.
- serOut  output  1  serial line; idles at 1.
- ready  output  1  idle and able to accept start.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse during the stop bit.

Function
REQ-003 The frame SHALL be sent in this order: start bit 0; dest as 2 bits, MSB first; len as 4 bits, MSB first; N data bits, data[0] first; stop bit 1.
REQ-004 With start=1 and ready=1 in cycle T, the block SHALL capture dest, len and data in cycle T and drive the start bit on serOut in cycle T+1.
REQ-005 serOut SHALL be registered, and each bit SHALL be held for exactly one clk cycle.
REQ-006 Total frame length SHALL be 8+N cycles, from the start bit through the stop bit inclusive.
REQ-007 The state machine SHALL have the states IDLE, STRT, SDST, SLEN, SDAT and STOP:
- IDLE->STRT on an accepted start.
- STRT->SDST after 1 cycle.
- SDST->SLEN after 2 cycles.
- SLEN->SDAT after 4 cycles, or SLEN->STOP when N=0.
- SDAT->STOP after N cycles.
- STOP->IDLE after 1 cycle.
REQ-008 len=0 SHALL produce no data bits; the frame is then 8 cycles.
REQ-009 start SHALL be ignored whenever ready=0.
REQ-010 Changes on dest, len or data after capture SHALL NOT affect the frame in flight.
REQ-011 ready SHALL be 1 only in IDLE.
REQ-012 busy SHALL equal not ready.
REQ-013 done SHALL be 1 only in the STOP cycle.
REQ-014 start held high continuously SHALL produce back-to-back frames separated by exactly one idle cycle (serOut=1, ready=1).
REQ-015 Data bits data[14:N] SHALL never be transmitted.
REQ-016 The bit counter SHALL be 4 bits wide, clear on every state entry, and never wrap within a phase.

Reset
REQ-017 Asserting rst (low) SHALL immediately force IDLE, serOut=1, ready=1, busy=0, done=0, and clear the counter and captured registers, including when asserted mid-frame.
REQ-018 After rst deasserts, the first accepted start SHALL produce a complete, well-formed frame.

Configuration
REQ-019 When MSSD_TX_GUARD_EN is defined, the block SHALL add a GARD state between STOP and IDLE that holds serOut=1 with ready=0 for 2 cycles, so back-to-back frames are separated by 3 idle cycles.
REQ-020 When MSSD_TX_GUARD_EN is undefined, STOP SHALL go directly to IDLE and REQ-014 SHALL apply unchanged.

Structure
REQ-021 The shared package mssd_pkg SHALL hold:
- the state enum;
- DEST_W=2, LEN_W=4, DATA_W=15;
- IDLE_LVL=1, START_LVL=0, STOP_LVL=1;
- phase length constants DST_BITS=2, LEN_BITS=4.
REQ-022 The bit counter SHALL be the single sub-module mssd_bit_cnt, with ports clk, rst, clr, en, limit[3:0] and endCnt.
REQ-023 endCnt SHALL assert when count == limit-1 and en=1.
REQ-024 All remaining control and shift logic SHALL reside in mssd_frame_tx.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- dest=2'b10, len=4, data=15'h000B with start pulsed at T -> serOut from T+1 = 0,1,0,0,1,0,0,1,1,0,1,1 then 1; done at T+12.
- len=0, dest=3 -> serOut = 0,1,1,0,0,0,0,1; done at T+8; the next start is accepted at T+9.
- len=15, data=15'h7FFF with start held high -> two 23-cycle frames separated by 1 idle cycle; 3 idle cycles when MSSD_TX_GUARD_EN is defined.
- data changed to 15'h0000 at T+5 of a len=3, data=15'h0007 frame -> data bits are still 1,1,1.
- start pulsed while busy=1 at T+4 -> ignored; exactly one frame is sent.
- rst low at T+6 of a len=8 frame -> serOut=1, ready=1 within the same cycle; a fresh frame after release is correct.
